// File: rtl/inst_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch (with cotm32_pkg core constants)
// Purpose  : Instruction prefetcher. It issues sequential 32-bit fetches from
//            fetch_pc into an in-order memory, buffers the responses in a
//            DEPTH-entry queue and presents them to the consumer. Traps, mret
//            and taken branches flush the queue and restart fetching.
//            Misaligned or out-of-range fetch addresses produce a single
//            faulting NOP entry, and fetching parks in HOLD until a redirect.
// Ports    : i_clk, i_rst             clock, synchronous active-high reset
//            o_req_valid/i_req_ready/o_req_addr     memory request channel
//            i_rsp_valid/i_rsp_data                 in-order memory response
//            o_inst_valid/i_inst_ready/o_inst/o_inst_addr/o_inst_addr_4
//                                                   consumer channel
//            o_t_inst_addr_misaligned/o_t_inst_access_fault  head-entry faults
//            i_trap_req/i_mtvec, i_trap_mret/i_mepc, i_take_branch/i_new_addr
//                                                   redirect sources
//            i_stall                                gates dequeue only
// Revision : 1.0 - initial release
// ============================================================================

package cotm32_pkg;
  localparam int XLEN  = 32;
  localparam int MXLEN = 32;
  localparam logic [XLEN-1:0] INST_MEM_START = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_MEM_END   = 32'h0000_FFFF;
endpackage

module inst_prefetch
  import cotm32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] IMEM_START   = INST_MEM_START,
  parameter logic [XLEN-1:0] IMEM_END     = INST_MEM_END
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // memory request channel
  output logic             o_req_valid,
  input  logic             i_req_ready,
  output logic [XLEN-1:0]  o_req_addr,
  // memory response channel
  input  logic             i_rsp_valid,
  input  logic [31:0]      i_rsp_data,
  // consumer channel
  output logic             o_inst_valid,
  input  logic             i_inst_ready,
  output logic [31:0]      o_inst,
  output logic [XLEN-1:0]  o_inst_addr,
  output logic [XLEN-1:0]  o_inst_addr_4,
  output logic             o_t_inst_addr_misaligned,
  output logic             o_t_inst_access_fault,
  // redirect / control
  input  logic             i_trap_req,
  input  logic [MXLEN-1:0] i_mtvec,
  input  logic             i_trap_mret,
  input  logic [MXLEN-1:0] i_mepc,
  input  logic             i_take_branch,
  input  logic [XLEN-1:0]  i_new_addr,
  input  logic             i_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_pc;       // next address to request
  logic [XLEN-1:0] r_rsp_pc;   // address of the next response that will be kept
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;

  logic [31:0]     r_q_inst [DEPTH];
  logic [XLEN-1:0] r_q_addr [DEPTH];
  logic            r_q_mis  [DEPTH];
  logic            r_q_acc  [DEPTH];

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic            w_below;
  logic            w_above;
  logic            w_out_of_range;
  logic            w_pc_bad;
  logic [CW:0]     w_occ;
  logic            w_slot_free;
  logic            w_rsp;
  logic            w_rsp_drop;
  logic            w_rsp_enq;
  logic            w_req_hs;
  logic            w_fault_enq;
  logic            w_enq;
  logic            w_deq;
  logic [CW-1:0]   w_inflight_nxt;
  logic [31:0]     w_enq_inst;
  logic [XLEN-1:0] w_enq_addr;
  logic            w_enq_mis;
  logic            w_enq_acc;

  // --------------------------------------------------------------------------
  // Redirect selection: trap > mret > branch
  // --------------------------------------------------------------------------
  assign w_redirect = i_trap_req | i_trap_mret | i_take_branch;
  assign w_target   = i_trap_req  ? i_mtvec :
                      i_trap_mret ? i_mepc  : i_new_addr;

  // --------------------------------------------------------------------------
  // Fetch address legality. A zero start address disables the lower check.
  // --------------------------------------------------------------------------
  assign w_misaligned = (r_pc[1:0] != 2'b00);

  generate
    if (IMEM_START != '0) begin : g_lo_chk
      assign w_below = (r_pc < IMEM_START);
    end else begin : g_no_lo_chk
      assign w_below = 1'b0;
    end
  endgenerate

  assign w_above        = (r_pc > IMEM_END);
  assign w_out_of_range = w_below | w_above;
  assign w_pc_bad       = w_misaligned | w_out_of_range;

  // Queued entries plus outstanding requests (including ones to be dropped)
  // can never exceed DEPTH, so every response always has a slot.
  assign w_occ       = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_slot_free = (w_occ < (CW+1)'(DEPTH));

  // A response with nothing outstanding cannot belong to this epoch.
  assign w_rsp      = i_rsp_valid & (r_inflight != '0);
  assign w_rsp_drop = w_rsp & ((r_drop != '0) | w_redirect);
  assign w_rsp_enq  = w_rsp & (r_drop == '0) & ~w_redirect;

  assign w_req_hs   = o_req_valid & i_req_ready;
  assign w_deq      = o_inst_valid & i_inst_ready & ~i_stall & ~w_redirect;
  assign w_enq      = w_rsp_enq | w_fault_enq;

  assign w_inflight_nxt = r_inflight + CW'(w_req_hs) - CW'(w_rsp);

  assign w_enq_inst = w_fault_enq ? C_NOP : i_rsp_data;
  assign w_enq_addr = w_fault_enq ? r_pc  : r_rsp_pc;
  assign w_enq_mis  = w_fault_enq & w_misaligned;
  assign w_enq_acc  = w_fault_enq & ~w_misaligned & w_out_of_range;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_valid = 1'b0;
    w_fault_enq = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (!i_rst && !w_pc_bad && w_slot_free) begin
          o_req_valid = 1'b1;
        end
        // The fault entry is inserted only once every earlier response has
        // returned, so it lands behind them in program order and never
        // collides with a response enqueue.
        if (!i_rst && !w_redirect && w_pc_bad && (r_inflight == '0) && w_slot_free) begin
          w_fault_enq = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_state_nxt = ST_HOLD;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
    if (w_redirect) begin
      w_state_nxt = ST_FETCH;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch pointers, counters and queue storage
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RESET_VECTOR;
      r_rsp_pc   <= RESET_VECTOR;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_addr[i] <= '0;
        r_q_mis[i]  <= 1'b0;
        r_q_acc[i]  <= 1'b0;
      end
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_redirect) begin
        // Everything still outstanding after this edge, including a request
        // accepted right now, belongs to the old path.
        r_pc     <= w_target;
        r_rsp_pc <= w_target;
        r_drop   <= w_inflight_nxt;
        r_count  <= '0;
        r_wptr   <= '0;
        r_rptr   <= '0;
      end else begin
        if (w_req_hs) begin
          r_pc <= r_pc + XLEN'(4);
        end
        if (w_rsp_drop) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_rsp_enq) begin
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
        end
        if (w_enq) begin
          r_q_inst[r_wptr] <= w_enq_inst;
          r_q_addr[r_wptr] <= w_enq_addr;
          r_q_mis[r_wptr]  <= w_enq_mis;
          r_q_acc[r_wptr]  <= w_enq_acc;
          r_wptr           <= r_wptr + AW'(1);
        end
        if (w_deq) begin
          r_rptr <= r_rptr + AW'(1);
        end
        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: consumer side is driven from registers only
  // --------------------------------------------------------------------------
  assign o_req_addr               = r_pc;
  assign o_inst_valid             = (r_count != '0);
  assign o_inst                   = r_q_inst[r_rptr];
  assign o_inst_addr              = r_q_addr[r_rptr];
  assign o_inst_addr_4            = r_q_addr[r_rptr] + XLEN'(4);
  assign o_t_inst_addr_misaligned = r_q_mis[r_rptr];
  assign o_t_inst_access_fault    = r_q_acc[r_rptr];

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch
// Purpose  : Self-checking bench for inst_prefetch. A memory model answers
//            requests in order, a reference stream of expected deliveries is
//            rebuilt on every reset/redirect, and a monitor compares every
//            consumer handshake against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] IEND  = 32'h0000_00FF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst;
  logic        o_req_valid, i_req_ready;
  logic [31:0] o_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        o_inst_valid, i_inst_ready;
  logic [31:0] o_inst, o_inst_addr, o_inst_addr_4;
  logic        o_t_inst_addr_misaligned, o_t_inst_access_fault;
  logic        i_trap_req, i_trap_mret, i_take_branch, i_stall;
  logic [31:0] i_mtvec, i_mepc, i_new_addr;

  inst_prefetch #(
    .RESET_VECTOR(RV),
    .DEPTH       (DEPTH),
    .IMEM_START  (32'h0000_0000),
    .IMEM_END    (IEND)
  ) dut (
    .i_clk                   (clk),
    .i_rst                   (i_rst),
    .o_req_valid             (o_req_valid),
    .i_req_ready             (i_req_ready),
    .o_req_addr              (o_req_addr),
    .i_rsp_valid             (i_rsp_valid),
    .i_rsp_data              (i_rsp_data),
    .o_inst_valid            (o_inst_valid),
    .i_inst_ready            (i_inst_ready),
    .o_inst                  (o_inst),
    .o_inst_addr             (o_inst_addr),
    .o_inst_addr_4           (o_inst_addr_4),
    .o_t_inst_addr_misaligned(o_t_inst_addr_misaligned),
    .o_t_inst_access_fault   (o_t_inst_access_fault),
    .i_trap_req              (i_trap_req),
    .i_mtvec                 (i_mtvec),
    .i_trap_mret             (i_trap_mret),
    .i_mepc                  (i_mepc),
    .i_take_branch           (i_take_branch),
    .i_new_addr              (i_new_addr),
    .i_stall                 (i_stall)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;
  int n_deliv  = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hDEAD_BEEF;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: after a restart at 'start', the consumer must see the
  // sequential words start, start+4, ... up to the first illegal address,
  // which appears once as a NOP carrying its fault flag, and then nothing.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        mis;
    logic        acc;
  } exp_t;

  exp_t sb[$];

  function automatic void fill(input logic [31:0] start);
    logic [31:0] a;
    sb.delete();
    a = start;
    for (int k = 0; k < 80; k++) begin
      if (a[1:0] != 2'b00) begin
        sb.push_back('{a, 32'h0000_0013, 1'b1, 1'b0});
        break;
      end
      if (a > IEND) begin
        sb.push_back('{a, 32'h0000_0013, 1'b0, 1'b1});
        break;
      end
      sb.push_back('{a, mdata(a), 1'b0, 1'b0});
      a = a + 32'd4;
    end
  endfunction

  // --------------------------------------------------------------------------
  // Memory model: in-order responses after a per-request latency
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t pend[$];
  int    mem_lat  = 1;
  bit    mem_rand = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (i_rst) begin
      pend.delete();
    end else if (o_req_valid && i_req_ready) begin
      n_req++;
      chk("req_addr_legal", {127'd0, (o_req_addr > IEND) || (o_req_addr[1:0] != 2'b00)}, 128'd0);
      pend.push_back('{o_req_addr, cyc + (mem_rand ? int'($urandom_range(1, 3)) : mem_lat)});
    end
  end

  initial begin
    pend_t p;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      i_rsp_valid = 1'b0;
      i_rsp_data  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p           = pend.pop_front();
        i_rsp_valid = 1'b1;
        i_rsp_data  = mdata(p.a);
      end
      i_req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: every consumer handshake pops one expected entry
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (!i_rst && o_inst_valid && i_inst_ready && !i_stall &&
        !(i_trap_req || i_trap_mret || i_take_branch)) begin
      n_deliv++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: actual addr=%0h required=no delivery", o_inst_addr);
      end else begin
        e = sb.pop_front();
        chk("deliver {addr,inst,mis,acc,addr4}",
            {o_inst_addr, o_inst, o_t_inst_addr_misaligned, o_t_inst_access_fault, o_inst_addr_4},
            {e.a, e.d, e.mis, e.acc, e.a + 32'd4});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic tr, input logic mr, input logic br,
                             input logic [31:0] mtvec, input logic [31:0] mepc,
                             input logic [31:0] naddr, input logic [31:0] exp_tgt);
    i_trap_req    = tr;
    i_trap_mret   = mr;
    i_take_branch = br;
    i_mtvec       = mtvec;
    i_mepc        = mepc;
    i_new_addr    = naddr;
    fill(exp_tgt);
    tick();
    i_trap_req    = 1'b0;
    i_trap_mret   = 1'b0;
    i_take_branch = 1'b0;
    @(negedge clk);
    chk("valid_after_redirect", {127'd0, o_inst_valid}, 128'd0);
  endtask

  int          n0, d0, bad;
  logic        tr, mr, br;
  logic [31:0] t0, t1, t2, tgt;

  function automatic logic [31:0] rand_target();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    if (sel == 1) return 32'(32'h100 + $urandom_range(0, 63) * 4);
    return 32'($urandom_range(0, 63) * 4);
  endfunction

  initial begin
    i_rst = 1'b1;
    i_inst_ready = 1'b0;
    i_stall = 1'b0;
    i_trap_req = 1'b0;
    i_trap_mret = 1'b0;
    i_take_branch = 1'b0;
    i_mtvec = '0;
    i_mepc = '0;
    i_new_addr = '0;
    fill(RV);

    // ---- reset values ----
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_valid",  {127'd0, o_req_valid}, 128'd0);
    chk("rst_inst_valid", {127'd0, o_inst_valid}, 128'd0);
    chk("rst_inst",       {96'd0, o_inst}, 128'd0);
    chk("rst_inst_addr",  {96'd0, o_inst_addr}, 128'd0);
    chk("rst_faults",     {126'd0, o_t_inst_addr_misaligned, o_t_inst_access_fault}, 128'd0);
    tick();
    i_rst = 1'b0;
    n0 = n_req;
    @(negedge clk);
    chk("req_valid_after_rst", {127'd0, o_req_valid}, 128'd1);
    chk("req_addr_after_rst",  {96'd0, o_req_addr}, {96'd0, RV});

    // ---- backpressure: consumer stalled, queue fills with exactly DEPTH ----
    repeat (10) tick();
    chk("bp_request_count", 128'(n_req - n0), 128'(DEPTH));
    @(negedge clk);
    chk("bp_req_valid_low", {127'd0, o_req_valid}, 128'd0);
    chk("bp_inst_valid",    {127'd0, o_inst_valid}, 128'd1);

    // ---- release: continuous streaming with no gaps ----
    tick();
    i_inst_ready = 1'b1;
    d0 = n_deliv;
    repeat (20) tick();
    chk("stream_no_gaps", 128'(n_deliv - d0), 128'd20);

    // ---- branch with several responses outstanding ----
    mem_lat = 3;
    repeat (8) tick();
    tick();
    do_redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_00C0, 32'h0000_00C0);
    repeat (15) tick();

    // ---- all three redirect sources at once: trap wins ----
    do_redirect(1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0040, 32'h0000_0200, 32'h0000_0080);
    repeat (12) tick();
    chk("trap_prio_progress", {127'd0, (sb.size() < 29)}, 128'd1);

    // ---- misaligned branch: one fault entry, no requests, park ----
    tick();
    mem_lat = 1;
    do_redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0102, 32'h0000_0102);
    bad = 0;
    repeat (12) begin
      tick();
      @(negedge clk);
      if (o_req_valid) bad++;
    end
    chk("hold_no_req", 128'(bad), 128'd0);
    chk("misaligned_delivered", 128'(sb.size()), 128'd0);
    tick();
    do_redirect(1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 32'h0000_0080);

    // ---- sequential run off the end of instruction memory ----
    repeat (60) tick();
    chk("afault_stream_done", 128'(sb.size()), 128'd0);
    @(negedge clk);
    chk("afault_hold_req", {127'd0, o_req_valid}, 128'd0);

    // ---- reset mid-stream ----
    tick();
    do_redirect(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 32'h0000_0000);
    repeat (10) tick();
    i_rst = 1'b1;
    fill(RV);
    tick();
    i_rst = 1'b0;
    @(negedge clk);
    chk("valid_after_midrst", {127'd0, o_inst_valid}, 128'd0);
    d0 = n_deliv;
    repeat (20) tick();
    chk("restart_progress", {127'd0, (n_deliv - d0) >= 10}, 128'd1);

    // ---- randomized traffic ----
    mem_rand = 1'b1;
    repeat (1500) begin
      tick();
      i_inst_ready = ($urandom_range(0, 9) < 7);
      i_stall      = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 399) == 0) begin
        i_rst = 1'b1;
        fill(RV);
        tick();
        i_rst = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        tr = ($urandom_range(0, 3) == 0);
        mr = ($urandom_range(0, 3) == 0);
        br = ($urandom_range(0, 1) == 0);
        if (!tr && !mr && !br) br = 1'b1;
        t0 = rand_target();
        t1 = rand_target();
        t2 = rand_target();
        tgt = tr ? t0 : (mr ? t1 : t2);
        do_redirect(tr, mr, br, t0, t1, t2, tgt);
      end
    end

    // ---- drain: redirect to a known start and let it run out ----
    tick();
    mem_rand = 1'b0;
    i_inst_ready = 1'b1;
    i_stall = 1'b0;
    do_redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_00E0, 32'h0, 32'h0000_00E0);
    repeat (40) tick();
    chk("final_drain", 128'(sb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
